wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 105 ++++++++++
 tb/tb_wb_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback arbiter: pipeline results and load returns share one register-file write port.
// Define WB_FWD_EN to expose the registered write as fwd_valid/fwd_addr/fwd_data for read bypass.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    output logic        pipe_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_addr,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    output logic        we,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
`ifdef WB_FWD_EN
    output logic        fwd_valid,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data,
`endif
    output logic [1:0]  pend_cnt
);

    // Handshake: a request transfers on a cycle where its valid and ready are both 1.
    // Each ready is computed from registered state only, never from the requester's valid.

    logic [4:0]  ent0_addr, ent1_addr;
    logic [31:0] ent0_data, ent1_data;
    logic [1:0]  starv;

    logic        forced;
    logic        push;
    logic        pop;
    logic        pipe_serve;
    logic        served;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic        push_slot;
    logic [1:0]  starv_next;
    logic [1:0]  pend_next;

    always_comb begin
        forced     = rst_n && (starv == 2'd3) && (pend_cnt != 2'd0);
        pipe_ready = rst_n && !forced;
        lsu_ready  = rst_n && (pend_cnt != 2'd2);
        push       = lsu_valid && lsu_ready;
        pipe_serve = pipe_valid && pipe_ready;
        pop        = rst_n && (pend_cnt != 2'd0) && !pipe_serve;
        served     = pipe_serve || pop;
        sel_addr   = pipe_serve ? pipe_addr : ent0_addr;
        sel_data   = pipe_serve ? pipe_data : ent0_data;
        // Slot the new entry lands in once the head (if popped) has shifted out.
        push_slot  = (pend_cnt == 2'd2) || ((pend_cnt == 2'd1) && !pop);
        pend_next  = pend_cnt + 2'(push) - 2'(pop);
        starv_next = starv;
        if (pop || (pend_cnt == 2'd0)) begin
            starv_next = 2'd0;
        end else if (pipe_serve) begin
            starv_next = starv + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0_addr <= '0;
            ent0_data <= '0;
            ent1_addr <= '0;
            ent1_data <= '0;
            pend_cnt  <= '0;
            starv     <= '0;
            we        <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            if (pop) begin
                ent0_addr <= ent1_addr;
                ent0_data <= ent1_data;
            end
            if (push && !push_slot) begin
                ent0_addr <= lsu_addr;
                ent0_data <= lsu_data;
            end
            if (push && push_slot) begin
                ent1_addr <= lsu_addr;
                ent1_data <= lsu_data;
            end
            pend_cnt <= pend_next;
            starv    <= starv_next;
            // GPR 0 is hardwired: the request is consumed but never written.
            we       <= served && (sel_addr != 5'd0);
            if (served) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = we;
    assign fwd_addr  = wr_addr;
    assign fwd_data  = wr_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: queue-based reference model checked every cycle plus literal spot checks.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        pipe_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  pend_cnt;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    wb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_valid (pipe_valid),
        .pipe_addr  (pipe_addr),
        .pipe_data  (pipe_data),
        .pipe_ready (pipe_ready),
        .lsu_valid  (lsu_valid),
        .lsu_addr   (lsu_addr),
        .lsu_data   (lsu_data),
        .lsu_ready  (lsu_ready),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`ifdef WB_FWD_EN
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
`endif
        .pend_cnt   (pend_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: state as it stands after the most recent rising edge
    logic [36:0] exp_q[$];
    int          m_starv = 0;
    bit          m_we    = 0;
    logic [4:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;

    always @(negedge clk) begin
        bit          forced;
        bit          exp_pr;
        bit          exp_lr;
        bit          served;
        bit          popped;
        bit          pipe_win;
        int          old_size;
        logic [36:0] head;
        forced = (m_starv == 3) && (exp_q.size() > 0);
        exp_pr = rst_n && !forced;
        exp_lr = rst_n && (exp_q.size() < 2);
        chk("pipe_ready", 32'(pipe_ready), 32'(exp_pr));
        chk("lsu_ready",  32'(lsu_ready),  32'(exp_lr));
        chk("we",         32'(we),         32'(m_we));
        chk("wr_addr",    32'(wr_addr),    32'(m_addr));
        chk("wr_data",    wr_data,         m_data);
        chk("pend_cnt",   32'(pend_cnt),   32'(exp_q.size()));
`ifdef WB_FWD_EN
        chk("fwd_valid",  32'(fwd_valid),  32'(m_we));
        chk("fwd_addr",   32'(fwd_addr),   32'(m_addr));
        chk("fwd_data",   fwd_data,        m_data);
`endif
        if (!rst_n) begin
            exp_q.delete();
            m_starv = 0;
            m_we    = 0;
            m_addr  = '0;
            m_data  = '0;
        end else begin
            old_size = exp_q.size();
            pipe_win = pipe_valid && !forced;
            popped   = !pipe_win && (old_size > 0);
            served   = pipe_win || popped;
            if (pipe_win) begin
                m_addr = pipe_addr;
                m_data = pipe_data;
            end else if (popped) begin
                head   = exp_q.pop_front();
                m_addr = head[36:32];
                m_data = head[31:0];
            end
            m_we = served && (m_addr != 5'd0);
            if (lsu_valid && exp_lr) exp_q.push_back({lsu_addr, lsu_data});
            if (popped || old_size == 0) m_starv = 0;
            else if (pipe_win) m_starv = m_starv + 1;
        end
    end

    // driver tasks
    task automatic drive(input bit r, input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                         input bit lv, input logic [4:0] la, input logic [31:0] ld);
        @(posedge clk);
        #1;
        rst_n      = r;
        pipe_valid = pv;
        pipe_addr  = pa;
        pipe_data  = pd;
        lsu_valid  = lv;
        lsu_addr   = la;
        lsu_data   = ld;
    endtask

    task automatic step(input bit r, input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                        input bit lv, input logic [4:0] la, input logic [31:0] ld);
        drive(r, pv, pa, pd, lv, la, ld);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        rst_n = 0; pipe_valid = 0; pipe_addr = '0; pipe_data = '0;
        lsu_valid = 0; lsu_addr = '0; lsu_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_pend", 32'(pend_cnt), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);

        // pipeline write, FIFO empty
        step(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        chk("t1_pipe_ready", 32'(pipe_ready), 32'd1);
        idle();
        chk("t1_we", 32'(we), 32'd1);
        chk("t1_addr", 32'(wr_addr), 32'd5);
        chk("t1_data", wr_data, 32'hDEADBEEF);

        // write to GPR 0 is consumed silently; idle holds address/data
        step(1, 1, 5'd0, 32'h12345678, 0, 5'd0, 32'd0);
        chk("t2_pipe_ready", 32'(pipe_ready), 32'd1);
        idle();
        chk("t2_we", 32'(we), 32'd0);
        chk("t2_addr", 32'(wr_addr), 32'd0);
        chk("t2_data", wr_data, 32'h12345678);
        idle();
        chk("t2_hold_we", 32'(we), 32'd0);
        chk("t2_hold_data", wr_data, 32'h12345678);

        // three loads behind a busy pipeline; then starvation forces the head out
        step(1, 1, 5'd1, 32'h1, 1, 5'd10, 32'hA0A0A0A0);
        chk("t3_lr1", 32'(lsu_ready), 32'd1);
        step(1, 1, 5'd2, 32'h2, 1, 5'd11, 32'hB1B1B1B1);
        chk("t3_lr2", 32'(lsu_ready), 32'd1);
        step(1, 1, 5'd3, 32'h3, 1, 5'd12, 32'hC2C2C2C2);
        chk("t3_lr3", 32'(lsu_ready), 32'd0);
        chk("t3_pend", 32'(pend_cnt), 32'd2);
        step(1, 1, 5'd4, 32'h4, 0, 5'd0, 32'd0);
        chk("t3_pr4", 32'(pipe_ready), 32'd1);
        step(1, 1, 5'd6, 32'h6, 0, 5'd0, 32'd0);
        chk("t3_forced", 32'(pipe_ready), 32'd0);
        idle();
        chk("t3_we", 32'(we), 32'd1);
        chk("t3_addr", 32'(wr_addr), 32'd10);
        chk("t3_data", wr_data, 32'hA0A0A0A0);
        chk("t3_pend1", 32'(pend_cnt), 32'd1);
        idle();
        chk("t3_addr2", 32'(wr_addr), 32'd11);
        chk("t3_data2", wr_data, 32'hB1B1B1B1);
        idle();

        // one entry, pipeline held: three pipe wins then forced pop of addr 7
        step(1, 0, 5'd0, 32'd0, 1, 5'd7, 32'h77777777);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 5'(20 + i), 32'(i), 0, 5'd0, 32'd0);
            chk("t4_pr", 32'(pipe_ready), 32'd1);
        end
        step(1, 1, 5'd23, 32'h23, 0, 5'd0, 32'd0);
        chk("t4_forced", 32'(pipe_ready), 32'd0);
        idle();
        chk("t4_we", 32'(we), 32'd1);
        chk("t4_addr", 32'(wr_addr), 32'd7);
        chk("t4_data", wr_data, 32'h77777777);

        // simultaneous push/pop at one entry keeps order
        step(1, 0, 5'd0, 32'd0, 1, 5'd8, 32'h88888888);
        step(1, 0, 5'd0, 32'd0, 1, 5'd9, 32'h99999999);
        chk("t5_lr", 32'(lsu_ready), 32'd1);
        idle();
        chk("t5_addr8", 32'(wr_addr), 32'd8);
        chk("t5_pend", 32'(pend_cnt), 32'd1);
        idle();
        chk("t5_addr9", 32'(wr_addr), 32'd9);
        chk("t5_data9", wr_data, 32'h99999999);
        chk("t5_pend0", 32'(pend_cnt), 32'd0);

        // reset with two buffered loads and live requests
        step(1, 1, 5'd22, 32'h22, 1, 5'd13, 32'hD3D3D3D3);
        step(1, 1, 5'd24, 32'h24, 1, 5'd14, 32'hE4E4E4E4);
        step(0, 1, 5'd25, 32'h25, 1, 5'd15, 32'hF5F5F5F5);
        chk("t6_pr_rst", 32'(pipe_ready), 32'd0);
        chk("t6_lr_rst", 32'(lsu_ready), 32'd0);
        idle();
        chk("t6_pend", 32'(pend_cnt), 32'd0);
        chk("t6_we", 32'(we), 32'd0);
        chk("t6_addr", 32'(wr_addr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t6_no_write", 32'(we), 32'd0);
        end

        // mixed traffic table
        for (int i = 0; i < 24; i++) begin
            step(1, (i % 3) != 0, 5'(i + 1), 32'hA5000000 + 32'(i),
                 (i % 2) == 1, 5'(31 - i), 32'h5A000000 + 32'(i));
        end
        repeat (4) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
